if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address fetched first after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port freeze  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-005 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-006 SHALL have port branch_addr  input  32  redirect target byte address.
REQ-007 SHALL have port mem_addr  output  32  byte address to instruction memory; equals the current PC.
REQ-008 SHALL have port mem_data  input  32  instruction word, combinationally valid in the same cycle as mem_addr.
REQ-009 SHALL have port if_pc  output  32  registered PC+4 of the captured instruction.
REQ-010 SHALL have port if_instr  output  32  registered instruction word (IF/ID).
REQ-011 SHALL have port if_valid  output  1  IF/ID holds a real instruction.
REQ-012 SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-013 SHALL have port fetch_count  output  32  number of instructions captured with if_valid=1.

Function
REQ-014 SHALL keep a 32-bit PC register and drive mem_addr = PC combinationally, with PC[1:0] always 2'b00.
REQ-015 SHALL implement an FSM with states RUN and HALT; reset enters RUN.
REQ-016 SHALL apply per-cycle priority: reset > branch_taken > freeze > HALT > normal fetch.
REQ-017 On branch_taken=1, in either state and regardless of freeze, SHALL do all of the following on the next edge: load PC <= {branch_addr[31:2],2'b00}; clear if_valid and if_instr to 0; hold if_pc; go to RUN.
REQ-018 On freeze=1 with branch_taken=0, SHALL hold PC, if_pc, if_instr, if_valid, fetch_count and FSM state unchanged.
REQ-019 Normal fetch in RUN with mem_data != 0 SHALL do all of the following on the next edge: PC <= PC+4; if_instr <= mem_data; if_pc <= PC+4; if_valid <= 1.
REQ-020 In RUN, a mem_data of 32'h0000_0000 SHALL be treated as end-of-program and, on the next edge, SHALL do all of the following: set if_valid to 0 and if_instr to 0; hold PC; enter HALT.
REQ-021 In HALT without branch_taken, SHALL hold PC, keep if_valid=0 and keep if_instr=0; halted=1 combinationally from state.
REQ-022 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, with no flag raised.
REQ-023 fetch_count SHALL increment by 1 on each edge where if_valid is loaded with 1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-024 Fetch-to-IF/ID latency SHALL be exactly one cycle; a branch costs exactly one bubble cycle at if_valid.

Reset
REQ-025 When rst_n=0 at a rising edge, SHALL set PC=RESET_PC, if_pc=0, if_instr=0, if_valid=0, fetch_count=0 and state=RUN, overriding every other input.
REQ-026 Reset asserted mid-stall, mid-branch or in HALT SHALL give the same result as REQ-025; mem_addr SHALL equal RESET_PC in the first cycle after reset.

Structure
REQ-027 Shared package SHALL hold the FSM state typedef (RUN, HALT), the constant INSTR_BYTES=4 and the constant END_OF_PROGRAM=32'h0000_0000.
REQ-028 The IF/ID register (if_pc, if_instr, if_valid with hold and clear controls) SHALL be a separate sub-module named if_id_reg; PC, FSM and counter logic stay in the top.

Verification
REQ-029 Test 1: reset, memory words 0x00220000 at 0, 0x00640000 at 4, 0x00A60000 at 8, no freeze -> if_instr sequence 0x00220000, 0x00640000, 0x00A60000 on cycles 1-3 after reset; if_pc 4, 8, 12; fetch_count 3.
REQ-030 Test 2: freeze=1 for 2 cycles while PC=8 -> mem_addr stays 8, IF/ID and fetch_count are unchanged, and fetch resumes at 8 the cycle after release.
REQ-031 Test 3: branch_taken=1 with branch_addr=0x0000_0013 while freeze=1 -> next PC=0x10, if_valid=0 for one cycle, then the instruction at 0x10 is captured.
REQ-032 Test 4: unmapped address returns 0 -> next cycle halted=1, if_valid=0, PC frozen; a later branch_taken to 0 -> RUN and the word at 0 is refetched.
REQ-033 Test 5: branch to 0xFFFF_FFFC with a nonzero word there -> the captured if_pc is 0x0000_0000 and the next mem_addr is 0x0000_0000.
REQ-034 Test 6: rst_n=0 for one cycle during HALT with fetch_count=5 -> all outputs are at reset values and mem_addr=RESET_PC on the next cycle.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and fetch-related constants.
package if_fetch_unit_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES    = 32'd4;
   localparam logic [31:0] END_OF_PROGRAM = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captured PC+4, instruction word and valid bit.
// Clear empties the slot but keeps the PC; hold freezes everything.
module if_id_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        hold_i,
   input  logic        load_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   // Next-state selection: clear beats hold beats load.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      unique case (1'b1)
         clear_i: begin
            instr_d = '0;
            valid_d = 1'b0;
         end
         hold_i: begin
         end
         load_i: begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Slot registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALT FSM, fetch counter and IF/ID slot.
// A zero instruction word ends the program; a branch restarts fetching.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  cnt_q, cnt_d;
   logic [31:0]  pc_plus4;
   logic         clear, hold, load;
   logic         unused_addr_lsbs;

   assign unused_addr_lsbs = ^branch_addr[1:0];
   assign pc_plus4 = pc_q + INSTR_BYTES;

   // Per-cycle control: branch > freeze > halt > end-of-program > fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      clear   = 1'b0;
      hold    = 1'b0;
      load    = 1'b0;
      if (branch_taken) begin
         pc_d    = {branch_addr[31:2], 2'b00};
         state_d = RUN;
         clear   = 1'b1;
      end else if (freeze) begin
         hold = 1'b1;
      end else if (state_q == HALT) begin
         clear = 1'b1;
      end else if (mem_data == END_OF_PROGRAM) begin
         clear   = 1'b1;
         state_d = HALT;
      end else begin
         pc_d = pc_plus4;
         load = 1'b1;
      end
   end

   // Saturating count of instructions captured into IF/ID.
   always_comb begin
      cnt_d = cnt_q;
      if (load && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // PC, FSM state and counter with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= PC_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   if_id_reg u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (clear),
      .hold_i  (hold),
      .load_i  (load),
      .pc_i    (pc_plus4),
      .instr_i (mem_data),
      .pc_o    (if_pc),
      .instr_o (if_instr),
      .valid_o (if_valid)
   );

   assign mem_addr    = pc_q;
   assign halted      = (state_q == HALT);
   assign fetch_count = cnt_q;

endmodule
